// File: rtl/ec_control_unit.sv
// ec_control_unit
// ---------------------------------------------------------------------------
// Finite-state controller for the 8-bit accumulator machine (A register, PC,
// IR, 32x8 RAM, add/sub unit). Two modes:
//   program mode : operator keys bytes from the Input switches into RAM at
//                  consecutive addresses (AddrSel counter).
//   run mode     : fetch / decode / execute of the 3-bit-opcode ISA.
//
// Optional feature macro: EC_IN_WAIT_EN
//   defined   -> IN waits for an Enter rising edge before loading A.
//   undefined -> IN loads the Input switches unconditionally in one cycle.
//
// Ports
//   Clock                 rising-edge clock
//   Reset                 synchronous, active-low
//   Mode                  1 = program, 0 = run (sampled in START / PROG_IDLE)
//   Enter                 operator key (level, rise-detected internally)
//   IR[2:0]               opcode from the IR register
//   Aeq0, Apos            datapath status flags
//   IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub   datapath strobes
//   Asel[1:0]             A mux: 00 add/sub, 01 Input, 10 RAM, 11 zero
//   Halt                  high in HALT
//   programEn, Addrload, PRload   program-mode strobes
//   AddrSel[4:0]          program-mode write address counter
//   State[3:0]            current state encoding (debug / LEDs)
// ---------------------------------------------------------------------------
module ec_control_unit (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Mode,
  input  logic       Enter,
  input  logic [2:0] IR,
  input  logic       Aeq0,
  input  logic       Apos,
  output logic       IRload,
  output logic       PCload,
  output logic       JMPmux,
  output logic       Meminst,
  output logic       MemWr,
  output logic       Aload,
  output logic       Sub,
  output logic [1:0] Asel,
  output logic       Halt,
  output logic       programEn,
  output logic       Addrload,
  output logic       PRload,
  output logic [4:0] AddrSel,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    st_start      = 4'd0,
    st_fetch      = 4'd1,
    st_decode     = 4'd2,
    st_load       = 4'd3,
    st_store      = 4'd4,
    st_add        = 4'd5,
    st_sub        = 4'd6,
    st_in         = 4'd7,
    st_jz         = 4'd8,
    st_jpos       = 4'd9,
    st_halt       = 4'd10,
    st_prog_idle  = 4'd11,
    st_prog_latch = 4'd12,
    st_prog_write = 4'd13
  } state_t;

  state_t     state_reg, state_next;
  logic [4:0] addr_cnt_reg, addr_cnt_next;
  logic       enter_q_reg;
  logic       enter_rise;

  assign enter_rise = Enter & ~enter_q_reg;
  assign AddrSel    = addr_cnt_reg;
  assign State      = state_reg;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_reg    <= st_start;
      addr_cnt_reg <= 5'd0;
      enter_q_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_cnt_reg <= addr_cnt_next;
      enter_q_reg  <= Enter;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_cnt_next = addr_cnt_reg;
    IRload        = 1'b0;
    PCload        = 1'b0;
    JMPmux        = 1'b0;
    Meminst       = 1'b0;
    MemWr         = 1'b0;
    Aload         = 1'b0;
    Sub           = 1'b0;
    Asel          = 2'b00;
    Halt          = 1'b0;
    programEn     = 1'b0;
    Addrload      = 1'b0;
    PRload        = 1'b0;

    // Strobes are gated by Reset so that a reset landing in STORE or
    // PROG_WRITE never lets the write complete on that same edge.
    if (Reset) begin
      case (state_reg)
        st_start: begin
          if (Mode) begin
            state_next    = st_prog_idle;
            addr_cnt_next = 5'd0;
          end else begin
            state_next = st_fetch;
          end
        end
        st_fetch: begin
          IRload     = 1'b1;
          PCload     = 1'b1;
          state_next = st_decode;
        end
        st_decode: begin
          Meminst = 1'b1;
          case (IR)
            3'b000:  state_next = st_load;
            3'b001:  state_next = st_store;
            3'b010:  state_next = st_add;
            3'b011:  state_next = st_sub;
            3'b100:  state_next = st_in;
            3'b101:  state_next = st_jz;
            3'b110:  state_next = st_jpos;
            default: state_next = st_halt;
          endcase
        end
        st_load: begin
          Meminst    = 1'b1;
          Asel       = 2'b10;
          Aload      = 1'b1;
          state_next = st_fetch;
        end
        st_store: begin
          Meminst    = 1'b1;
          MemWr      = 1'b1;
          state_next = st_fetch;
        end
        st_add: begin
          Meminst    = 1'b1;
          Aload      = 1'b1;
          state_next = st_fetch;
        end
        st_sub: begin
          Meminst    = 1'b1;
          Sub        = 1'b1;
          Aload      = 1'b1;
          state_next = st_fetch;
        end
        st_in: begin
          Asel = 2'b01;
`ifdef EC_IN_WAIT_EN
          Aload = enter_rise;
          if (enter_rise) state_next = st_fetch;
`else
          Aload      = 1'b1;
          state_next = st_fetch;
`endif
        end
        st_jz: begin
          JMPmux     = 1'b1;
          PCload     = Aeq0;
          state_next = st_fetch;
        end
        st_jpos: begin
          JMPmux     = 1'b1;
          PCload     = Apos;
          state_next = st_fetch;
        end
        st_halt: begin
          Halt = 1'b1;
        end
        st_prog_idle: begin
          // Mode=0 has priority over a simultaneous Enter rise.
          if (!Mode)           state_next = st_start;
          else if (enter_rise) state_next = st_prog_latch;
        end
        st_prog_latch: begin
          Addrload   = 1'b1;
          PRload     = 1'b1;
          state_next = st_prog_write;
        end
        st_prog_write: begin
          programEn     = 1'b1;
          addr_cnt_next = addr_cnt_reg + 5'd1;
          state_next    = st_prog_idle;
        end
        default: state_next = st_start;
      endcase
    end
  end

endmodule
